alu_fpga_ctrl: RTL and testbench

Parametrised board-level controller for exercising the ALU on the DE2 FPGA. Four synchronised, debounced pushbuttons and the slide switches drive a small sequencer that loads operand A, operand B and the opcode into registers, executes once, and latches the result and flags. The registered display output shows the data on the HEX digits with paging. Results can also be chained back into operand A. The block sits between the board pins and an ALU instance; it drives the ALU's inputs and samples its outputs.

---
 rtl/alu_fpga_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_alu_fpga_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_fpga_ctrl.sv
// Board-level sequencer for driving an ALU from DE2 keys and switches.
// Debounced keys step operand/opcode entry, execute once, and show results on paged HEX digits.
module alu_fpga_ctrl #(
  parameter int DATA_W          = 32,
  parameter int DIGITS          = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  CLOCK_50,
  input  logic                  nRST,
  input  logic [3:0]            KEY,
  input  logic [17:0]           SW,
  output logic [DATA_W-1:0]     alu_porta,
  output logic [DATA_W-1:0]     alu_portb,
  output logic [3:0]            alu_op,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_negative,
  input  logic                  alu_overflow,
  input  logic                  alu_zero,
  output logic [7*DIGITS-1:0]   HEX,
  output logic [7:0]            LEDR
);

  // state    | meaning
  // ENTER_A  | switches shown live, enter loads operand A
  // ENTER_B  | switches shown live, enter loads operand B
  // ENTER_OP | SW[3:0] shown, enter loads opcode
  // EXEC     | single cycle, result and flags captured
  // RESULT   | result shown, enter restarts, chain feeds result into A

  localparam int PAGES  = (DATA_W + 4*DIGITS - 1) / (4*DIGITS);
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int EXT_W  = PAGES * 4 * DIGITS;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {ENTER_A, ENTER_B, ENTER_OP, EXEC, RESULT} state_t;

  state_t              state, state_nxt;
  logic [3:0]          sync1, sync2, deb, press;
  logic [CNT_W-1:0]    cnt [4];
  logic [DATA_W-1:0]   ext, res, disp_word;
  logic [EXT_W-1:0]    disp_ext;
  logic [4*DIGITS-1:0] page_nib;
  logic [2:0]          flags;
  logic [PAGE_W-1:0]   page;
  logic                enter, restart, page_p, chain;
  logic                ld_a_ext, ld_a_res, ld_b, ld_op, ld_res;
  logic                unused_sw;

  assign unused_sw = SW[17];
  assign enter     = press[0];
  assign restart   = press[1];
  assign page_p    = press[2];
  assign chain     = press[3];

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  // Press pulse is registered alongside the level change so it lasts exactly one cycle.
  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      deb   <= '1;
      press <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] != deb[k]) begin
          if (cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb[k]   <= sync2[k];
            cnt[k]   <= '0;
            press[k] <= ~sync2[k];
          end else begin
            cnt[k] <= cnt[k] + 1'b1;
          end
        end else begin
          cnt[k] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) state <= ENTER_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == EXEC) begin
      state_nxt = RESULT;
    end else if (restart) begin
      state_nxt = ENTER_A;
    end else if (chain && state == RESULT) begin
      state_nxt = ENTER_B;
    end else if (enter) begin
      case (state)
        ENTER_A:  state_nxt = ENTER_B;
        ENTER_B:  state_nxt = ENTER_OP;
        ENTER_OP: state_nxt = EXEC;
        RESULT:   state_nxt = ENTER_A;
        default:  state_nxt = ENTER_A;
      endcase
    end
  end

  always_comb begin
    ld_a_ext = 1'b0;
    ld_a_res = 1'b0;
    ld_b     = 1'b0;
    ld_op    = 1'b0;
    ld_res   = (state == EXEC);
    if (!restart) begin
      ld_a_res = chain && (state == RESULT);
      ld_a_ext = enter && (state == ENTER_A);
      ld_b     = enter && (state == ENTER_B);
      ld_op    = enter && (state == ENTER_OP);
    end
  end

  always_comb begin
    ext       = {DATA_W{SW[16]}};
    ext[15:0] = SW[15:0];
  end

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      alu_porta <= '0;
      alu_portb <= '0;
      alu_op    <= '0;
      res       <= '0;
      flags     <= '0;
      page      <= '0;
    end else begin
      if (ld_a_res)      alu_porta <= res;
      else if (ld_a_ext) alu_porta <= ext;
      if (ld_b)   alu_portb <= ext;
      if (ld_op)  alu_op    <= SW[3:0];
      if (ld_res) begin
        res   <= alu_out;
        flags <= {alu_negative, alu_overflow, alu_zero};
      end
      if (page_p) begin
        if (page == PAGE_W'(PAGES - 1)) page <= '0;
        else                            page <= page + 1'b1;
      end
    end
  end

  always_comb begin
    case (state)
      ENTER_A, ENTER_B: disp_word = ext;
      ENTER_OP:         disp_word = DATA_W'(SW[3:0]);
      default:          disp_word = res;
    endcase
  end

  // Zero-padded so nibbles past DATA_W on the last page show as 0.
  assign disp_ext = EXT_W'(disp_word);

  always_comb begin
    page_nib = '0;
    for (int p = 0; p < PAGES; p++)
      if (page == PAGE_W'(p)) page_nib = disp_ext[p*4*DIGITS +: 4*DIGITS];
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b0100111;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      HEX  <= '1;
      LEDR <= 8'b0000_1000;
    end else begin
      for (int k = 0; k < DIGITS; k++) HEX[7*k +: 7] <= seg7(page_nib[4*k +: 4]);
      LEDR <= {page[0], state == RESULT, state == ENTER_OP, state == ENTER_B,
               state == ENTER_A, flags};
    end
  end

endmodule

// File: tb/tb_alu_fpga_ctrl.sv
// Directed bench for alu_fpga_ctrl with a stubbed ALU, 4 digits over a 32-bit datapath (2 pages).
module tb_alu_fpga_ctrl;

  localparam int DATA_W = 32;
  localparam int DIGITS = 4;

  logic              CLOCK_50 = 1'b0;
  logic              nRST;
  logic [3:0]        KEY;
  logic [17:0]       SW;
  logic [DATA_W-1:0] alu_porta, alu_portb, alu_out;
  logic [3:0]        alu_op;
  logic              alu_negative, alu_overflow, alu_zero;
  logic [7*DIGITS-1:0] HEX;
  logic [7:0]        LEDR;

  int checks = 0;
  int errors = 0;

  alu_fpga_ctrl #(.DATA_W(DATA_W), .DIGITS(DIGITS), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50), .nRST(nRST), .KEY(KEY), .SW(SW),
    .alu_porta(alu_porta), .alu_portb(alu_portb), .alu_op(alu_op),
    .alu_out(alu_out), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .HEX(HEX), .LEDR(LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  function automatic logic [27:0] hex4(input logic [15:0] v);
    hex4 = {seg_tab[v[15:12]], seg_tab[v[11:8]], seg_tab[v[7:4]], seg_tab[v[3:0]]};
  endfunction

  typedef struct {
    logic [17:0] sw_a, sw_b, sw_op;
    logic [31:0] stub_res;
    logic [2:0]  stub_flags;
    logic [31:0] exp_a, exp_b;
    logic [3:0]  exp_op;
    logic [15:0] exp_disp;
    logic [7:0]  exp_ledr;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press_mask(input logic [3:0] mask, output int exec_cycles);
    exec_cycles = 0;
    KEY = KEY & ~mask;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (LEDR[6:3] == 4'b0000) exec_cycles++;
    end
    KEY = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (LEDR[6:3] == 4'b0000) exec_cycles++;
    end
  endtask

  task automatic press(input int k);
    int dummy;
    press_mask(4'(1 << k), dummy);
  endtask

  initial begin
    int ec;
    vecs[0] = '{18'h0FFFF, 18'h10000, 18'h0000F, 32'h0000_0000, 3'b001,
                32'h0000FFFF, 32'hFFFF0000, 4'hF, 16'h0000, 8'h41};
    vecs[1] = '{18'h18000, 18'h07FFF, 18'h12349, 32'h8000_1234, 3'b110,
                32'hFFFF8000, 32'h00007FFF, 4'h9, 16'h1234, 8'h46};
    vecs[2] = '{18'h0ABCD, 18'h1FFFF, 18'h0000A, 32'h0000_CAFE, 3'b100,
                32'h0000ABCD, 32'hFFFFFFFF, 4'hA, 16'hCAFE, 8'h44};
    vecs[3] = '{18'h10005, 18'h00003, 18'h00002, 32'h0000_0008, 3'b000,
                32'hFFFF0005, 32'h00000003, 4'h2, 16'h0008, 8'h40};

    nRST = 1'b0;
    KEY  = 4'hF;
    SW   = 18'h01234;
    alu_out = '0;
    {alu_negative, alu_overflow, alu_zero} = 3'b000;

    // Reset
    repeat (3) tick();
    check("rst_hex", 64'(HEX), 64'(28'hFFFFFFF));
    check("rst_ledr", 64'(LEDR), 64'h08);
    check("rst_porta", 64'(alu_porta), 64'h0);
    check("rst_portb", 64'(alu_portb), 64'h0);
    check("rst_op", 64'(alu_op), 64'h0);
    nRST = 1'b1;
    repeat (2) tick();
    check("post_rst_hex", 64'(HEX), 64'(hex4(16'h1234)));
    check("post_rst_ledr", 64'(LEDR), 64'h08);

    // Debounce: short bounce ignored, stable press lands exactly on the 7th edge
    KEY[0] = 1'b0;
    repeat (3) tick();
    KEY[0] = 1'b1;
    repeat (10) tick();
    check("bounce_ledr", 64'(LEDR), 64'h08);
    check("bounce_porta", 64'(alu_porta), 64'h0);
    KEY[0] = 1'b0;
    repeat (6) tick();
    check("latency_early", 64'(alu_porta), 64'h0);
    tick();
    check("latency_exact", 64'(alu_porta), 64'h00001234);
    KEY[0] = 1'b1;
    repeat (10) tick();
    check("deb_enter_b", 64'(LEDR), 64'h10);
    press(1);
    check("restart_ledr", 64'(LEDR), 64'h08);
    check("restart_keeps_a", 64'(alu_porta), 64'h00001234);

    // Full sequences
    for (int v = 0; v < 4; v++) begin
      press(1);
      SW = vecs[v].sw_a;
      press(0);
      check("vec_porta", 64'(alu_porta), 64'(vecs[v].exp_a));
      SW = vecs[v].sw_b;
      press(0);
      check("vec_portb", 64'(alu_portb), 64'(vecs[v].exp_b));
      SW = vecs[v].sw_op;
      repeat (2) tick();
      check("vec_op_disp", 64'(HEX), 64'(hex4({12'h000, vecs[v].exp_op})));
      alu_out = vecs[v].stub_res;
      {alu_negative, alu_overflow, alu_zero} = vecs[v].stub_flags;
      press_mask(4'b0001, ec);
      check("vec_exec_cycles", 64'(ec), 64'd1);
      check("vec_op", 64'(alu_op), 64'(vecs[v].exp_op));
      check("vec_res_hex", 64'(HEX), 64'(hex4(vecs[v].exp_disp)));
      check("vec_res_ledr", 64'(LEDR), 64'(vecs[v].exp_ledr));
      if (v < 3) begin
        press(0);
        check("vec_back_a", 64'(LEDR), 64'({5'b00001, vecs[v].stub_flags}));
      end
    end

    // Chain from RESULT, then ignored in ENTER_B
    press(3);
    check("chain_porta", 64'(alu_porta), 64'h00000008);
    check("chain_ledr", 64'(LEDR), 64'h10);
    press(3);
    check("chain_ign_porta", 64'(alu_porta), 64'h00000008);
    check("chain_ign_ledr", 64'(LEDR), 64'h10);
    SW = 18'h0BEEF;
    repeat (2) tick();
    check("live_ext_hex", 64'(HEX), 64'(hex4(16'hBEEF)));

    // Simultaneous presses
    SW = 18'h00003;
    press(0);
    SW = 18'h00002;
    alu_out = 32'h55;
    {alu_negative, alu_overflow, alu_zero} = 3'b000;
    press(0);
    check("sim_res_hex", 64'(HEX), 64'(hex4(16'h0055)));
    check("sim_res_ledr", 64'(LEDR), 64'h40);
    press_mask(4'b1011, ec);
    check("sim_restart_ledr", 64'(LEDR), 64'h08);
    check("sim_restart_porta", 64'(alu_porta), 64'h00000008);
    SW = 18'h00007;
    press(0);
    press(0);
    press(0);
    check("sim_pre_porta", 64'(alu_porta), 64'h00000007);
    press_mask(4'b1001, ec);
    check("sim_chain_ledr", 64'(LEDR), 64'h10);
    check("sim_chain_porta", 64'(alu_porta), 64'h00000055);

    // Paging
    press(1);
    alu_out = 32'hDEADBEEF;
    press(0);
    press(0);
    press(0);
    check("page0_hex", 64'(HEX), 64'(hex4(16'hBEEF)));
    check("page0_ledr", 64'(LEDR), 64'h40);
    press(2);
    check("page1_hex", 64'(HEX), 64'(hex4(16'hDEAD)));
    check("page1_ledr", 64'(LEDR), 64'hC0);
    press(2);
    check("page_wrap_hex", 64'(HEX), 64'(hex4(16'hBEEF)));
    check("page_wrap_ledr", 64'(LEDR), 64'h40);
    press(2);

    // Asynchronous reset mid-sequence
    nRST = 1'b0;
    #2;
    check("async_hex", 64'(HEX), 64'(28'hFFFFFFF));
    check("async_ledr", 64'(LEDR), 64'h08);
    check("async_porta", 64'(alu_porta), 64'h0);
    check("async_portb", 64'(alu_portb), 64'h0);
    check("async_op", 64'(alu_op), 64'h0);
    tick();
    nRST = 1'b1;
    repeat (2) tick();
    check("after_async_hex", 64'(HEX), 64'(hex4(16'h0007)));
    check("after_async_ledr", 64'(LEDR), 64'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
